// File: rtl/text_render_pipe.sv
// Text-mode pixel pipeline: coordinate -> text buffer -> character ROM -> mono pixel.
// Three register stages; sync/blank travel alongside the pixel, and the underline cursor blinks.
module text_render_pipe #(
    parameter int COLS            = 80,
    parameter int ROWS            = 60,
    parameter int ADDR_W          = 13,
    parameter int BLINK_FRAMES    = 30,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic              video_on,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              cursor_en,
    input  logic [6:0]        cursor_col,
    input  logic [5:0]        cursor_row,
    output logic [ADDR_W-1:0] text_addr,
    input  logic [8:0]        text_data,
    output logic [8:0]        char_code,
    output logic [3:0]        line_number,
    input  logic [7:0]        char_line,
    output logic              pixel_on,
    output logic              video_on_out,
    output logic              hsync_out,
    output logic              vsync_out
);

    localparam logic SYNC_OFF = SYNC_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic SYNC_ON  = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
    localparam logic [9:0] COLS_L = 10'(COLS);
    localparam logic [9:0] ROWS_L = 10'(ROWS);
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_FRAMES - 1);

    logic [6:0]        col_s;
    logic [6:0]        row_s;
    logic              in_grid_s;
    logic              cur_hit_s;
    logic [ADDR_W-1:0] addr_s;
    logic              vs_edge_s;
    logic              glyph_bit_s;
    logic              pix_s;

    logic [2:0] s1_xl_r, s2_xl_r;
    logic [2:0] s1_yl_r, s2_yl_r;
    logic       s1_vis_r, s2_vis_r;
    logic       s1_von_r, s2_von_r;
    logic       s1_hs_r, s2_hs_r;
    logic       s1_vs_r, s2_vs_r;
    logic       s1_cur_r, s2_cur_r;

    logic [CNT_W-1:0] frame_cnt_r;
    logic             phase_r;
    logic             vs_prev_r;

    assign col_s = pixel_x[9:3];
    assign row_s = pixel_y[9:3];

    assign char_code   = text_data;
    assign line_number = {1'b0, s2_yl_r};

    // Cell decode: grid membership, cursor match and linear buffer address
    always_comb begin
        in_grid_s = ({3'b000, col_s} < COLS_L) && ({3'b000, row_s} < ROWS_L);
        // in_grid gating keeps an off-grid cursor position from ever matching
        cur_hit_s = cursor_en && in_grid_s && (col_s == cursor_col) &&
                    (row_s == {1'b0, cursor_row}) && (pixel_y[2:0] == 3'd7);
        if (in_grid_s) begin
            addr_s = ADDR_W'(row_s) * ADDR_W'(COLS) + ADDR_W'(col_s);
        end else begin
            addr_s = {ADDR_W{1'b0}};
        end
    end

    // Glyph bit select (MSB is leftmost) and cursor overlay for the output stage
    always_comb begin
        glyph_bit_s = char_line[3'd7 - s2_xl_r];
        if (s2_vis_r) begin
            pix_s = glyph_bit_s || (s2_cur_r && phase_r);
        end else begin
            pix_s = 1'b0;
        end
    end

    assign vs_edge_s = (vsync_in == SYNC_ON) && (vs_prev_r != SYNC_ON);

    // Stages 1 and 2: buffer address plus the side fields that travel with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            text_addr <= {ADDR_W{1'b0}};
            s1_xl_r   <= 3'd0;
            s1_yl_r   <= 3'd0;
            s1_vis_r  <= 1'b0;
            s1_von_r  <= 1'b0;
            s1_hs_r   <= SYNC_OFF;
            s1_vs_r   <= SYNC_OFF;
            s1_cur_r  <= 1'b0;
            s2_xl_r   <= 3'd0;
            s2_yl_r   <= 3'd0;
            s2_vis_r  <= 1'b0;
            s2_von_r  <= 1'b0;
            s2_hs_r   <= SYNC_OFF;
            s2_vs_r   <= SYNC_OFF;
            s2_cur_r  <= 1'b0;
        end else begin
            text_addr <= addr_s;
            s1_xl_r   <= pixel_x[2:0];
            s1_yl_r   <= pixel_y[2:0];
            s1_vis_r  <= video_on && in_grid_s;
            s1_von_r  <= video_on;
            s1_hs_r   <= hsync_in;
            s1_vs_r   <= vsync_in;
            s1_cur_r  <= cur_hit_s;
            s2_xl_r   <= s1_xl_r;
            s2_yl_r   <= s1_yl_r;
            s2_vis_r  <= s1_vis_r;
            s2_von_r  <= s1_von_r;
            s2_hs_r   <= s1_hs_r;
            s2_vs_r   <= s1_vs_r;
            s2_cur_r  <= s1_cur_r;
        end
    end

    // Stage 3: registered pixel and delayed sync/blank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_on     <= 1'b0;
            video_on_out <= 1'b0;
            hsync_out    <= SYNC_OFF;
            vsync_out    <= SYNC_OFF;
        end else begin
            pixel_on     <= pix_s;
            video_on_out <= s2_von_r;
            hsync_out    <= s2_hs_r;
            vsync_out    <= s2_vs_r;
        end
    end

    // Blink: count vsync assertion edges, toggle phase on wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_r <= {CNT_W{1'b0}};
            phase_r     <= 1'b1;
            vs_prev_r   <= SYNC_OFF;
        end else begin
            vs_prev_r <= vsync_in;
            if (vs_edge_s) begin
                if (frame_cnt_r == CNT_MAX) begin
                    frame_cnt_r <= {CNT_W{1'b0}};
                    phase_r     <= ~phase_r;
                end else begin
                    frame_cnt_r <= frame_cnt_r + CNT_W'(1);
                end
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_text_render_pipe.sv
// Scoreboard bench for text_render_pipe: stimulus pushes expectations from a cell/glyph model,
// a monitor pops and compares each cycle the DUT output is due.
module tb_text_render_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  pixel_x, pixel_y;
    logic        video_on, hsync_in, vsync_in, cursor_en;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic [12:0] text_addr;
    logic [8:0]  text_data = 9'd0;
    logic [8:0]  char_code;
    logic [3:0]  line_number;
    logic [7:0]  char_line;
    logic        pixel_on, video_on_out, hsync_out, vsync_out;

    always #5 clk = ~clk;

    text_render_pipe dut (
        .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .text_addr(text_addr), .text_data(text_data), .char_code(char_code),
        .line_number(line_number), .char_line(char_line), .pixel_on(pixel_on),
        .video_on_out(video_on_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    logic [8:0] tbuf [0:4799];

    function automatic logic [7:0] font(input logic [8:0] code, input logic [3:0] line);
        int v;
        if (code == 9'd0) return 8'h00;
        if (code == 9'h041 && line == 4'd0) return 8'h18;
        v = int'(code) * 37 + int'(line) * 91 + 13;
        return 8'(v) ^ 8'(code >> 2);
    endfunction

    assign char_line = font(char_code, line_number);

    always @(posedge clk) text_data <= (text_addr < 13'd4800) ? tbuf[text_addr] : 9'd0;

    typedef struct { int due; logic pon; logic von; logic hs; logic vs; int tag; } pexp_t;
    typedef struct { int due; logic [12:0] addr; int tag; } aexp_t;
    pexp_t pq[$];
    aexp_t aq[$];

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int m_cnt;
    bit m_phase;
    bit m_vprev;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic model_reset();
        m_cnt   = 0;
        m_phase = 1'b1;
        m_vprev = 1'b1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_pix(input int due, input logic pon, input logic von,
                            input logic hs, input logic vs, input int tag);
        pexp_t e;
        e.due = due; e.pon = pon; e.von = von; e.hs = hs; e.vs = vs; e.tag = tag;
        pq.push_back(e);
    endtask

    // One pixel per call; rel releases reset in the same cycle the pixel is presented.
    task automatic drive(input int x, input int y, input bit von, input bit hs, input bit vs,
                         input bit cen, input int ccol, input int crow, input int tag, input bit rel);
        int col, row, line;
        bit ingrid, hit, gbit;
        logic [7:0] g;
        aexp_t a;
        @(posedge clk);
        #1;
        if (rel) begin
            rst_n = 1'b1;
            model_reset();
            push_pix(cyc + 1, 1'b0, 1'b0, 1'b1, 1'b1, 90);
            push_pix(cyc + 2, 1'b0, 1'b0, 1'b1, 1'b1, 91);
        end
        pixel_x = 10'(x); pixel_y = 10'(y);
        video_on = von; hsync_in = hs; vsync_in = vs;
        cursor_en = cen; cursor_col = 7'(ccol); cursor_row = 6'(crow);
        if (!vs && m_vprev) begin
            m_cnt++;
            if (m_cnt == 30) begin
                m_cnt = 0;
                m_phase = !m_phase;
            end
        end
        m_vprev = vs;
        col = x / 8; row = y / 8; line = y % 8;
        ingrid = (col < 80) && (row < 60);
        hit = cen && ingrid && (col == ccol) && (row == crow) && (line == 7);
        g = ingrid ? font(tbuf[row * 80 + col], 4'(line)) : 8'h00;
        gbit = g[7 - x % 8];
        push_pix(cyc + 3, von && ingrid && (gbit || (hit && m_phase)), von, hs, vs, tag);
        a.due = cyc + 1;
        a.addr = ingrid ? 13'(row * 80 + col) : 13'd0;
        a.tag = tag;
        aq.push_back(a);
    endtask

    task automatic vpulse();
        drive(0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 5, 2, 8, 1'b0);
        drive(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 5, 2, 8, 1'b0);
    endtask

    task automatic cursor_line(input int y, input int tag);
        for (int x = 40; x < 48; x++) drive(x, y, 1'b1, 1'b1, 1'b1, 1'b1, 5, 2, tag, 1'b0);
    endtask

    // Monitor: compare every output whose due cycle has arrived
    initial begin : monitor
        pexp_t me;
        aexp_t ma;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                while (pq.size() > 0 && pq[0].due < cyc) begin
                    tests++; fails++;
                    $display("FAIL pix_missed tag=%0d due=%0d cyc=%0d", pq[0].tag, pq[0].due, cyc);
                    void'(pq.pop_front());
                end
                if (pq.size() > 0 && pq[0].due == cyc) begin
                    me = pq.pop_front();
                    tests++;
                    if ({pixel_on, video_on_out, hsync_out, vsync_out} !== {me.pon, me.von, me.hs, me.vs}) begin
                        fails++;
                        $display("FAIL pix tag=%0d cyc=%0d got pon/von/hs/vs=%b%b%b%b expected %b%b%b%b",
                                 me.tag, cyc, pixel_on, video_on_out, hsync_out, vsync_out,
                                 me.pon, me.von, me.hs, me.vs);
                    end
                end
                while (aq.size() > 0 && aq[0].due < cyc) begin
                    tests++; fails++;
                    $display("FAIL addr_missed tag=%0d", aq[0].tag);
                    void'(aq.pop_front());
                end
                if (aq.size() > 0 && aq[0].due == cyc) begin
                    ma = aq.pop_front();
                    tests++;
                    if (text_addr !== ma.addr) begin
                        fails++;
                        $display("FAIL text_addr tag=%0d cyc=%0d got %0d expected %0d",
                                 ma.tag, cyc, text_addr, ma.addr);
                    end
                end
            end
        end
    end

    initial begin : stim
        int ccol, crow, x, y, guard;
        for (int i = 0; i < 4800; i++) tbuf[i] = 9'($urandom_range(0, 511));
        tbuf[0]   = 9'h041;
        tbuf[165] = 9'h000;
        rst_n = 1'b0;
        pixel_x = 10'd0; pixel_y = 10'd0; video_on = 1'b0;
        hsync_in = 1'b1; vsync_in = 1'b1; cursor_en = 1'b0;
        cursor_col = 7'd0; cursor_row = 6'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_pixel_on", 32'(pixel_on), 32'd0);
        chk("rst_video_on_out", 32'(video_on_out), 32'd0);
        chk("rst_hsync_out", 32'(hsync_out), 32'd1);
        chk("rst_vsync_out", 32'(vsync_out), 32'd1);
        chk("rst_text_addr", 32'(text_addr), 32'd0);
        chk("rst_char_code", 32'(char_code), 32'h041);

        // Cell (0,0) glyph line 0 = 0x18
        for (int i = 0; i < 8; i++) drive(i, 0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1, i == 0);
        drive(639, 479, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 2, 1'b0);
        drive(640, 0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 3, 1'b0);
        drive(640, 479, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 3, 1'b0);
        drive(0, 480, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 3, 1'b0);
        drive(3, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 3, 1'b0);

        // Cursor at (5,2) over a blank cell, then blink phases
        cursor_line(23, 4);
        cursor_line(22, 5);
        repeat (30) vpulse();
        cursor_line(23, 6);
        repeat (30) vpulse();
        cursor_line(23, 7);

        // Mid-line reset while the cursor is lit
        for (int x2 = 40; x2 < 46; x2++) drive(x2, 23, 1'b1, 1'b0, 1'b1, 1'b1, 5, 2, 9, 1'b0);
        #2;
        chk("pre_reset_pon", 32'(pixel_on), 32'd1);
        rst_n = 1'b0;
        pq.delete();
        aq.delete();
        #1;
        chk("async_rst_pixel_on", 32'(pixel_on), 32'd0);
        chk("async_rst_hsync", 32'(hsync_out), 32'd1);
        chk("async_rst_vsync", 32'(vsync_out), 32'd1);
        chk("async_rst_von", 32'(video_on_out), 32'd0);
        chk("async_rst_addr", 32'(text_addr), 32'd0);
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        repeat (2) @(posedge clk);
        for (int x2 = 40; x2 < 48; x2++) drive(x2, 23, 1'b1, 1'b1, 1'b1, 1'b1, 5, 2, 10, x2 == 40);

        // Random syncs/blanking, cursor off
        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 1023), $urandom_range(0, 1023), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 0, 0, 11, 1'b0);

        // Random cursor position with vsync held inactive
        for (int s = 0; s < 4; s++) begin
            ccol = $urandom_range(0, 79);
            crow = $urandom_range(0, 59);
            repeat (3) drive(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 12, 1'b0);
            for (int i = 0; i < 60; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    x = ccol * 8 + $urandom_range(0, 7);
                    y = crow * 8 + $urandom_range(6, 7);
                end else begin
                    x = $urandom_range(0, 700);
                    y = $urandom_range(0, 500);
                end
                drive(x, y, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b1,
                      1'b1, ccol, crow, 13, 1'b0);
            end
        end

        // Off-grid cursor column/row never draws
        for (int c = 0; c < 128; c++)
            drive(c * 8 + $urandom_range(0, 7), 23, 1'b1, 1'b1, 1'b1, 1'b1, 100, 2, 14, 1'b0);
        for (int c = 0; c < 80; c += 7)
            drive(c * 8 + $urandom_range(0, 7), 7 + 8 * $urandom_range(0, 59), 1'b1, 1'b1, 1'b1,
                  1'b1, c, 61, 15, 1'b0);

        guard = 0;
        while ((pq.size() > 0 || aq.size() > 0) && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        @(posedge clk);
        if (pq.size() > 0 || aq.size() > 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", pq.size() + aq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
